// File: rtl/fifo_chain_if.sv
// fifo_chain handshake bundle: producer/consumer side is master,
// the FIFO itself is slave. Error flags exist only with FIFO_CHAIN_ERR_EN.
interface fifo_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d_in;
  logic             d_in_strobe;
  logic [WIDTH-1:0] q_out;
  logic             q_out_strobe;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
`ifdef FIFO_CHAIN_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output d_in, d_in_strobe, q_out_strobe,
    input  q_out, empty, full, almost_full, count
`ifdef FIFO_CHAIN_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  d_in, d_in_strobe, q_out_strobe,
    output q_out, empty, full, almost_full, count
`ifdef FIFO_CHAIN_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/fifo_chain.sv
// Shift-through FIFO of DEPTH chained elements with contiguous used flags.
// Optional sticky overflow/underflow flags via FIFO_CHAIN_ERR_EN.
module fifo_chain #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ALMOST = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  fifo_chain_if.slave   bus
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] nd   [DEPTH];
  logic [DEPTH-1:0] used;
  logic [DEPTH-1:0] nu;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic             is_empty;
  logic             is_full;
  logic             do_rd;
  logic             do_wr;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + CW'(used[i]);
  end

  assign is_empty = ~used[0];
  assign is_full  = used[DEPTH-1];
  assign do_rd    = bus.q_out_strobe & ~is_empty;
  // A full chain still accepts a write when the head leaves on the same edge.
  assign do_wr    = bus.d_in_strobe & (~is_full | do_rd);
  assign idx      = do_rd ? cnt - CW'(1) : cnt;

  always_comb begin
    nd = data;
    nu = used;
    if (do_rd) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        nd[i] = data[i+1];
        nu[i] = used[i+1];
      end
      nd[DEPTH-1] = '0;
      nu[DEPTH-1] = 1'b0;
    end
    if (do_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == idx) begin
          nd[i] = bus.d_in;
          nu[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        data[i] <= '0;
      used <= '0;
    end else begin
      data <= nd;
      used <= nu;
    end
  end

  assign bus.q_out       = data[0];
  assign bus.count       = cnt;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (cnt >= CW'(ALMOST));

`ifdef FIFO_CHAIN_ERR_EN
  logic ovf;
  logic unf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (bus.d_in_strobe & is_full & ~bus.q_out_strobe)
        ovf <= 1'b1;
      if (bus.q_out_strobe & is_empty)
        unf <= 1'b1;
    end
  end

  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
`endif

endmodule

// File: tb/tb_fifo_chain.sv
// Directed plus random checks of fifo_chain against a queue model.
// Error-flag checks compile in only with FIFO_CHAIN_ERR_EN.
module tb_fifo_chain;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   fails = 0;
  int   passed;

  logic [7:0] mq [$];
  bit         m_ov = 1'b0;
  bit         m_un = 1'b0;

  fifo_chain_if #(.WIDTH(8), .DEPTH(4)) bus ();

  fifo_chain #(.WIDTH(8), .DEPTH(4), .ALMOST(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] eq;
    int n;
    n  = mq.size();
    eq = (n > 0) ? mq[0] : 8'h00;
    chk({tag, "_q"},     32'(bus.q_out),       32'(eq));
    chk({tag, "_cnt"},   32'(bus.count),       32'(n));
    chk({tag, "_empty"}, 32'(bus.empty),       32'(n == 0));
    chk({tag, "_full"},  32'(bus.full),        32'(n == 4));
    chk({tag, "_af"},    32'(bus.almost_full), 32'(n >= 3));
`ifdef FIFO_CHAIN_ERR_EN
    chk({tag, "_ovf"},   32'(bus.overflow),    32'(m_ov));
    chk({tag, "_unf"},   32'(bus.underflow),   32'(m_un));
`endif
  endtask

  // Drive one cycle, advance the model by the FIFO rules, check #1 after edge.
  task automatic step(input string tag, input bit w, input bit r,
                      input logic [7:0] d);
    bit was_full;
    bus.d_in_strobe  = w;
    bus.q_out_strobe = r;
    bus.d_in         = d;
    @(posedge clk);
    was_full = (mq.size() == 4);
    if (r && mq.size() == 0) m_un = 1'b1;
    if (w && was_full && !r) m_ov = 1'b1;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (w && mq.size() < 4) mq.push_back(d);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mq.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    #1;
    chk_model("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.d_in         = '0;
    bus.d_in_strobe  = 1'b0;
    bus.q_out_strobe = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    step("t1_wr", 1, 0, 8'hAA);
    chk("t1_aa", 32'(bus.q_out), 32'h0000_00AA);

    do_reset();
    step("t2_w1", 1, 0, 8'h11);
    step("t2_w2", 1, 0, 8'h22);
    step("t2_w3", 1, 0, 8'h33);
    chk("t2_af3", 32'(bus.almost_full), 32'd1);
    step("t2_w4", 1, 0, 8'h44);
    chk("t2_full", 32'(bus.full), 32'd1);
    step("t2_w5", 1, 0, 8'h55);
    chk("t2_drop", 32'(bus.count), 32'd4);

    step("t3_r1", 0, 1, 8'h00);
    chk("t3_22", 32'(bus.q_out), 32'h22);
    step("t3_r2", 0, 1, 8'h00);
    step("t3_r3", 0, 1, 8'h00);
    chk("t3_44", 32'(bus.q_out), 32'h44);
    step("t3_r4", 0, 1, 8'h00);
    chk("t3_empty", 32'(bus.empty), 32'd1);
    step("t3_r5", 0, 1, 8'h00);
    chk("t3_q0", 32'(bus.q_out), 32'h00);

    do_reset();
    step("t4_w1", 1, 0, 8'h11);
    step("t4_w2", 1, 0, 8'h22);
    step("t4_rw", 1, 1, 8'h77);
    chk("t4_22", 32'(bus.q_out), 32'h22);
    chk("t4_c2", 32'(bus.count), 32'd2);
    step("t4_r", 0, 1, 8'h00);
    chk("t4_77", 32'(bus.q_out), 32'h77);

    do_reset();
    step("t5_w1", 1, 0, 8'h11);
    step("t5_w2", 1, 0, 8'h22);
    step("t5_w3", 1, 0, 8'h33);
    step("t5_w4", 1, 0, 8'h44);
    step("t5_rw", 1, 1, 8'h99);
    chk("t5_c4", 32'(bus.count), 32'd4);
    step("t5_r1", 0, 1, 8'h00);
    step("t5_r2", 0, 1, 8'h00);
    step("t5_r3", 0, 1, 8'h00);
    chk("t5_99", 32'(bus.q_out), 32'h99);
    step("t5_r4", 0, 1, 8'h00);
    step("t5_erw", 1, 1, 8'h5A);
    chk("t5_c1", 32'(bus.count), 32'd1);
    chk("t5_5a", 32'(bus.q_out), 32'h5A);

    do_reset();
    step("t6_w1", 1, 0, 8'hC1);
    step("t6_w2", 1, 0, 8'hC2);
    step("t6_w3", 1, 0, 8'hC3);
    bus.d_in_strobe = 1'b0;
    #2;
    reset_n = 1'b0;
    mq.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    #1;
    chk_model("t6_async");
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 400; k++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom));
    end

    passed = total - fails;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
